// File: rtl/clarvi_split_sequencer.sv
// clarvi_split_sequencer: runs one 64-bit op as two 32-bit ALU beats, ordered by op class, and assembles the result.
module clarvi_split_sequencer (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_high_first,
  input  logic        in_is32,
  input  logic [63:0] in_rs1,
  input  logic [63:0] in_rs2,
  output logic        alu_part,
  output logic [31:0] alu_rs1,
  output logic [31:0] alu_rs2,
  output logic        alu_stall,
  input  logic [31:0] alu_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_result,
  input  logic        flush
);
  typedef enum logic [1:0] {IDLE, BEAT1, BEAT2, DONE} state_t;
  state_t r_state, w_next;
  logic [63:0] r_rs1, r_rs2, r_result;
  logic r_upper_first;
  logic w_accept;
  assign w_accept = in_valid && in_ready;
  always_ff @(posedge clock)
    r_state <= !reset ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    if (flush) w_next = IDLE;
    else
      case (r_state)
        IDLE:  w_next = w_accept ? BEAT1 : IDLE;
        BEAT1: w_next = BEAT2;
        BEAT2: w_next = DONE;
        DONE:  w_next = out_ready ? (in_valid ? BEAT1 : IDLE) : DONE;
      endcase
  end
  always_comb begin
    in_ready  = !flush && (r_state == IDLE || (r_state == DONE && out_ready));
    alu_stall = !(r_state == BEAT1 || r_state == BEAT2);
    alu_part  = r_state == BEAT1 ? r_upper_first : r_state == BEAT2 ? !r_upper_first : 1'b0;
    out_valid = r_state == DONE;
  end
  assign alu_rs1    = alu_part ? r_rs1[63:32] : r_rs1[31:0];
  assign alu_rs2    = alu_part ? r_rs2[63:32] : r_rs2[31:0];
  assign out_result = r_result;
  // W ops stay lower-first so the ALU can sign-extend from its carried state
  always_ff @(posedge clock)
    if (!reset) begin
      r_rs1         <= '0;
      r_rs2         <= '0;
      r_upper_first <= 1'b0;
      r_result      <= '0;
    end else begin
      if (w_accept) begin
        r_rs1         <= in_rs1;
        r_rs2         <= in_rs2;
        r_upper_first <= in_high_first && !in_is32;
      end
      if (!alu_stall) begin
        if (alu_part) r_result[63:32] <= alu_result;
        else r_result[31:0] <= alu_result;
      end
    end
endmodule

// File: tb/tb_clarvi_split_sequencer.sv
// tb_clarvi_split_sequencer: directed vectors for beat ordering, backpressure, flush and reset.
module tb_clarvi_split_sequencer;
  logic clock = 1'b0, reset = 1'b0;
  logic in_valid = 1'b0, in_high_first = 1'b0, in_is32 = 1'b0, out_ready = 1'b1, flush = 1'b0;
  logic [63:0] in_rs1 = '0, in_rs2 = '0;
  logic [31:0] alu_result = '0;
  logic in_ready, alu_part, alu_stall, out_valid;
  logic [31:0] alu_rs1, alu_rs2;
  logic [63:0] out_result;
  int n_cmp = 0, n_bad = 0;
  clarvi_split_sequencer dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_high_first(in_high_first), .in_is32(in_is32), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .alu_part(alu_part), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_stall(alu_stall),
    .alu_result(alu_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .flush(flush)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask
  initial begin
    @(negedge clock);
    step();
    #1;
    check("rst_ready", in_ready, 1);
    check("rst_valid", out_valid, 0);
    check("rst_stall", alu_stall, 1);
    check("rst_part", alu_part, 0);
    check("rst_result", out_result, 0);
    reset = 1'b1;
    step();
    check("idle_part", alu_part, 0);
    // lower-first
    in_valid = 1'b1; in_rs1 = 64'h00000001_FFFFFFFF; in_rs2 = 64'h0;
    #1 check("lf_ready", in_ready, 1);
    step();
    in_valid = 1'b0; alu_result = 32'h00000000;
    #1;
    check("lf_b1_part", alu_part, 0);
    check("lf_b1_rs1", alu_rs1, 32'hFFFFFFFF);
    check("lf_b1_stall", alu_stall, 0);
    check("lf_b1_valid", out_valid, 0);
    step();
    alu_result = 32'h00000002;
    #1;
    check("lf_b2_part", alu_part, 1);
    check("lf_b2_rs1", alu_rs1, 32'h00000001);
    step();
    alu_result = 32'hDEADBEEF;
    #1;
    check("lf_done_valid", out_valid, 1);
    check("lf_done_result", out_result, 64'h00000002_00000000);
    check("lf_done_stall", alu_stall, 1);
    step();
    check("lf_idle_valid", out_valid, 0);
    // upper-first, then held in DONE
    out_ready = 1'b0;
    in_valid = 1'b1; in_high_first = 1'b1; in_is32 = 1'b0; in_rs2 = 64'h12345678_9ABCDEF0;
    step();
    in_valid = 1'b0; alu_result = 32'hAAAAAAAA;
    #1;
    check("uf_b1_part", alu_part, 1);
    check("uf_b1_rs2", alu_rs2, 32'h12345678);
    step();
    alu_result = 32'h55555555;
    #1;
    check("uf_b2_part", alu_part, 0);
    check("uf_b2_rs2", alu_rs2, 32'h9ABCDEF0);
    step();
    alu_result = 32'h0BADF00D;
    in_valid = 1'b1; in_is32 = 1'b1; in_rs1 = 64'hCAFEBABE_01234567;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_valid", out_valid, 1);
      check("bp_result", out_result, 64'hAAAAAAAA_55555555);
      check("bp_stall", alu_stall, 1);
      check("bp_ready", in_ready, 0);
      step();
    end
    // release with a W op offered in the same cycle
    out_ready = 1'b1;
    #1 check("bp_release_ready", in_ready, 1);
    step();
    in_valid = 1'b0; alu_result = 32'h11111111;
    #1;
    check("w_b1_valid", out_valid, 0);
    check("w_b1_part", alu_part, 0);
    check("w_b1_rs1", alu_rs1, 32'h01234567);
    step();
    alu_result = 32'h22222222;
    #1;
    check("w_b2_part", alu_part, 1);
    check("w_b2_rs1", alu_rs1, 32'hCAFEBABE);
    step();
    check("w_done_valid", out_valid, 1);
    check("w_done_result", out_result, 64'h22222222_11111111);
    step();
    // flush in BEAT2 with a new op offered
    in_valid = 1'b1; in_high_first = 1'b0; in_is32 = 1'b0;
    step();
    in_valid = 1'b0;
    step();
    check("fl_b2_stall", alu_stall, 0);
    flush = 1'b1; in_valid = 1'b1;
    #1 check("fl_ready_low", in_ready, 0);
    step();
    check("fl_idle_valid", out_valid, 0);
    check("fl_idle_stall", alu_stall, 1);
    flush = 1'b0; in_valid = 1'b0;
    #1 check("fl_ready_after", in_ready, 1);
    step();
    check("fl_still_idle", out_valid, 0);
    check("fl_still_stall", alu_stall, 1);
    // reset in BEAT1
    in_valid = 1'b1; in_rs1 = 64'h1; alu_result = 32'h77777777;
    step();
    in_valid = 1'b0;
    check("rb_b1_stall", alu_stall, 0);
    reset = 1'b0;
    step();
    check("rb_ready", in_ready, 1);
    check("rb_valid", out_valid, 0);
    check("rb_result", out_result, 0);
    check("rb_rs1", alu_rs1, 0);
    reset = 1'b1;
    step();
    check("rb_after_valid", out_valid, 0);
    check("rb_after_stall", alu_stall, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
